// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// per-stage control bundle with its canned settings, and the counter width helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_REFILL   = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                     id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0,
                                     mem_wb_flush: 1'b1};
  localparam pipe_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                                       mem_wb_flush: 1'b1};
  localparam pipe_ctl_t CTL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1,
                                       mem_wb_flush: 1'b0};
  localparam pipe_ctl_t CTL_LU = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1,
                                   mem_wb_flush: 1'b0};
  localparam pipe_ctl_t CTL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                                       mem_wb_flush: 1'b0};
  localparam pipe_ctl_t CTL_REFILL = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                                       mem_wb_flush: 1'b0};

  // Down-counter width covering both the refill and the reset-hold spans.
  function automatic int cnt_width(input int imem_lat, input int rst_hold);
    int m;
    m = (imem_lat > rst_hold) ? imem_lat : rst_hold;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM status in, per-stage enables/flushes out.
// Optional HAZ_PERF_CNT_EN adds the two performance counters.
interface pipeline_hazard_ctrl_if;
  // No handshake: every signal is a level, sampled by the controller each cycle,
  // and the pipeline registers act on the enables/flushes at the next clk edge.
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       mem_wb_flush;
  logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, ctrl_state, stall_cycles, flush_events
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, ctrl_state, stall_cycles, flush_events
  );
`else
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, ctrl_state
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, ctrl_state
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: an EX load whose destination feeds the ID
// instruction. Kept standalone so a forwarding unit can reuse it.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu
);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu = ex_mem_read && (ex_rd != REG_X0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe (HOLD/RUN/MEM_WAIT/REFILL).
// Define HAZ_PERF_CNT_EN to add stall_cycles/flush_events counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int RST_HOLD = 2
) (
  input logic                 clk,
  input logic                 res,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CW = cnt_width(IMEM_LAT, RST_HOLD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_RST    = (RST_HOLD > 0) ? CW'(RST_HOLD - 1) : '0;
  localparam logic [CW-1:0] CNT_REFILL = (IMEM_LAT > 0) ? CW'(IMEM_LAT - 1) : '0;
  localparam ctrl_state_t   ST_RST     = (RST_HOLD > 0) ? ST_HOLD : ST_RUN;

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_q, ret_d;
  logic          lu;
  logic          refill_mode;
  pipe_ctl_t     ctl;

  load_use_detect u_lu (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_mem_read (hz.ex_mem_read),
    .ex_rd       (hz.ex_rd),
    .lu          (lu)
  );

  // A MEM_WAIT entered from REFILL resumes the refill with its count intact.
  assign refill_mode = (state_q == ST_REFILL) || ((state_q == ST_MEM_WAIT) && ret_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = 1'b0;
    ctl     = CTL_HOLD;
    if (state_q == ST_HOLD) begin
      ctl = CTL_HOLD;
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - CNT_ONE;
    end else if (hz.mem_busy) begin
      ctl     = CTL_FREEZE;
      state_d = ST_MEM_WAIT;
      ret_d   = refill_mode;
    end else if (hz.ex_branch_taken) begin
      ctl = CTL_BRANCH;
      if (IMEM_LAT > 0) begin
        state_d = ST_REFILL;
        cnt_d   = CNT_REFILL;
      end else begin
        state_d = ST_RUN;
      end
    end else if (refill_mode) begin
      // ID holds a fetched bubble here, so a load-use match is irrelevant.
      ctl = CTL_REFILL;
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_REFILL;
        cnt_d   = cnt_q - CNT_ONE;
      end
    end else if (lu) begin
      ctl     = CTL_LU;
      state_d = ST_RUN;
    end else begin
      ctl     = CTL_NORMAL;
      state_d = ST_RUN;
    end
    if (!res) ctl = CTL_HOLD;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_RST;
      cnt_q   <= CNT_RST;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  assign hz.pc_write     = ctl.pc_write;
  assign hz.if_id_write  = ctl.if_id_write;
  assign hz.if_id_flush  = ctl.if_id_flush;
  assign hz.id_ex_write  = ctl.id_ex_write;
  assign hz.id_ex_flush  = ctl.id_ex_flush;
  assign hz.ex_mem_write = ctl.ex_mem_write;
  assign hz.mem_wb_flush = ctl.mem_wb_flush;
  assign hz.ctrl_state   = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // CTL_BRANCH only arises from a redirect, whether from RUN, REFILL or MEM_WAIT.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_q != ST_HOLD) && !ctl.pc_write && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if ((ctl == CTL_BRANCH) && (flush_q != '1))                   flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (IMEM_LAT=2, RST_HOLD=2) with
// an expected-value queue drained by an independent monitor.
module tb_pipeline_hazard_ctrl;
  localparam int W = 9;

  // Output order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  // ex_mem_write, mem_wb_flush
  localparam logic [6:0] C_HOLD   = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BR     = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_REFILL = 7'b0111010;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;
  localparam logic [1:0] S_RF   = 2'd3;

  logic clk;
  logic res;
  pipeline_hazard_ctrl_if hz ();

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           failures;

  pipeline_hazard_ctrl #(.IMEM_LAT(2), .RST_HOLD(2)) dut (
    .clk (clk),
    .res (res),
    .hz  (hz)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver: apply one cycle of inputs just after the edge and queue the expectation.
  task automatic step(input logic r, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic mr,
                      input logic [4:0] rd, input logic br, input logic busy,
                      input logic [1:0] st, input logic [6:0] ctl, input string nm);
    @(posedge clk);
    #1;
    res                = r;
    hz.id_rs1          = rs1;
    hz.id_uses_rs1     = u1;
    hz.id_rs2          = rs2;
    hz.id_uses_rs2     = u2;
    hz.ex_mem_read     = mr;
    hz.ex_rd           = rd;
    hz.ex_branch_taken = br;
    hz.mem_busy        = busy;
    exp_q.push_back({st, ctl});
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [1:0] st, input logic [6:0] ctl, input string nm);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, st, ctl, nm);
  endtask

  // Monitor / scoreboard: outputs are valid every cycle, checked mid-cycle.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {hz.ctrl_state, hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
               hz.id_ex_flush, hz.ex_mem_write, hz.mem_wb_flush};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got state/ctl %b required %b at %0t", nm, got, exp, $time);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    res      = 1'b0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = '0; hz.ex_branch_taken = 1'b0; hz.mem_busy = 1'b0;

    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, S_HOLD, C_HOLD, "reset");
    idle(S_HOLD, C_HOLD, "hold_1");
    idle(S_HOLD, C_HOLD, "hold_2");
    idle(S_RUN, C_RUN, "run_after_hold");

    // Load-use via rs2, then the load advances
    step(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, S_RUN, C_LU, "lu_rs2");
    step(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, S_RUN, C_RUN, "lu_clear");
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, S_RUN, C_RUN, "x0_no_stall");
    step(1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, S_RUN, C_LU, "lu_rs1");
    step(1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, S_RUN, C_RUN, "lu_unused_src");

    // Branch with two refill cycles
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, S_RUN, C_BR, "branch");
    idle(S_RF, C_REFILL, "refill_cnt1");
    idle(S_RF, C_REFILL, "refill_cnt0");
    idle(S_RUN, C_RUN, "run_after_refill");

    // mem_busy for 3 cycles starting in REFILL with cnt=1
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, S_RUN, C_BR, "branch_2");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, S_RF, C_FREEZE, "freeze_in_refill");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, S_MW, C_FREEZE, "freeze_2");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, S_MW, C_FREEZE, "freeze_3");
    idle(S_MW, C_REFILL, "resume_refill_cnt1");
    idle(S_RF, C_REFILL, "resume_refill_cnt0");
    idle(S_RUN, C_RUN, "run_after_resume");

    // Simultaneous mem_busy and branch: freeze first, redirect when busy falls
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, S_RUN, C_FREEZE, "busy_br_1");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, S_MW, C_FREEZE, "busy_br_2");
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, S_MW, C_BR, "redirect_on_release");
    idle(S_RF, C_REFILL, "refill_after_wait_1");
    idle(S_RF, C_REFILL, "refill_after_wait_0");
    idle(S_RUN, C_RUN, "run_after_wait");

    // Load-use during REFILL is ignored
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, S_RUN, C_BR, "branch_3");
    step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, S_RF, C_REFILL, "lu_in_refill");
    idle(S_RF, C_REFILL, "refill_3");
    idle(S_RUN, C_RUN, "run_3");

    // MEM_WAIT from RUN resolves with RUN rules in the release cycle
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, S_RUN, C_FREEZE, "busy_run");
    step(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, S_MW, C_LU, "lu_on_release");
    idle(S_RUN, C_RUN, "run_4");

    // Reset mid-operation aborts REFILL immediately
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, S_RUN, C_BR, "branch_4");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, S_HOLD, C_HOLD, "reset_mid");
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, S_HOLD, C_HOLD, "reset_mid_2");
    idle(S_HOLD, C_HOLD, "rehold_1");
    idle(S_HOLD, C_HOLD, "rehold_2");
    idle(S_RUN, C_RUN, "rerun");

    // Drain: the monitor must consume every expectation within a few cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
